freq_meas_ctrl: RTL and testbench

Measurement sequencer for the frequency meter. It generates the counter clear, gate window and `Store` strobe that drive the count/period counters and the BCD output stage. It also selects `measure_mode` by auto-ranging between direct counting (mode 0) and period measurement (mode 1). It runs continuously while `run` is high and flags over-range and under-range results for the display.

---
 rtl/freq_meter_pkg.sv | 31 +++
 rtl/sync_edge_det.sv | 32 +++
 rtl/freq_meas_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_freq_meas_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: sequencer states, the measurement
// mode encoding and the default timing constants for a 50 MHz system clock.
package freq_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ARM,
        ST_GATE,
        ST_SETTLE,
        ST_DECIDE,
        ST_STORE,
        ST_HOLD
    } state_t;

    localparam logic MODE_COUNT  = 1'b0;
    localparam logic MODE_PERIOD = 1'b1;

    localparam int DEF_GATE_CYC    = 50_000_000;
    localparam int DEF_TIMEOUT_CYC = 100_000_000;
    localparam int DEF_SETTLE_CYC  = 4;
    localparam int DEF_HOLD_CYC    = 25_000_000;
    localparam int DEF_N_LOW       = 1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; rise is a registered one-cycle pulse, rise_next announces it a cycle early.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic rise_next
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
        end
    end

    // The value rise will carry on the next cycle; lets a registered consumer act on that cycle.
    assign rise_next = sync & ~sync_d;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the frequency meter: counter clear, gate window, store
// strobe, auto-ranging between direct count and period measurement, range flags.
module freq_meas_ctrl
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYC    = DEF_GATE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int N_LOW       = DEF_N_LOW
) (
    input  logic        CLK_50,
    input  logic        nRST,
    input  logic        run,
    input  logic        sig_in,
    input  logic        OF,
    input  logic [3:0]  LatchBCD3,
    input  logic [3:0]  LatchBCD2,
    input  logic [15:0] N,
    output logic        Clr,
    output logic        Gate,
    output logic        Store,
    output logic        measure_mode,
    output logic        over_range,
    output logic        under_range,
    output logic        busy
);

    localparam int CNT_W = $clog2(max3(GATE_CYC, SETTLE_CYC, HOLD_CYC) + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      N_LOW_V     = 16'(N_LOW);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tcnt;
    logic             range_used;
    logic             over_hit;
    logic             under_hit;
    logic             sig_rise;
    logic             sig_rise_next;
    logic             tmo_hit;
    logic             range_req;

    sync_edge_det u_sig_sync (
        .clk       (CLK_50),
        .rst_n     (nRST),
        .din       (sig_in),
        .rise      (sig_rise),
        .rise_next (sig_rise_next)
    );

    assign tmo_hit = (tcnt == TMO_LAST);

    // A range change is allowed once per HOLD-to-HOLD cycle; a second request simply stores.
    assign range_req = !range_used && !OF &&
                       ((measure_mode == MODE_COUNT) ? (LatchBCD3 == 4'd0 && LatchBCD2 == 4'd0)
                                                     : (N < N_LOW_V));

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            tcnt         <= '0;
            range_used   <= 1'b0;
            over_hit     <= 1'b0;
            under_hit    <= 1'b0;
            Clr          <= 1'b0;
            Gate         <= 1'b0;
            Store        <= 1'b0;
            measure_mode <= MODE_COUNT;
            over_range   <= 1'b0;
            under_range  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            Clr   <= 1'b0;
            Store <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_CLEAR;
                        Clr   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt  <= '0;
                    tcnt <= '0;
                    if (measure_mode == MODE_COUNT) begin
                        state <= ST_GATE;
                        Gate  <= 1'b1;
                    end else begin
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tmo_hit) begin
                        state       <= ST_STORE;
                        Store       <= 1'b1;
                        under_range <= 1'b1;
                        under_hit   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (sig_rise) begin
                            state <= ST_GATE;
                            Gate  <= 1'b1;
                        end
                    end
                end
                ST_GATE: begin
                    if (measure_mode == MODE_COUNT) begin
                        if (cnt == GATE_LAST) begin
                            state <= ST_SETTLE;
                            Gate  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state       <= ST_STORE;
                        Gate        <= 1'b0;
                        Store       <= 1'b1;
                        under_range <= 1'b1;
                        under_hit   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        // Closing on rise_next keeps Gate already low in the closing sig_rise cycle.
                        if (sig_rise_next) begin
                            state <= ST_SETTLE;
                            Gate  <= 1'b0;
                            cnt   <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    if (range_req) begin
                        state        <= ST_CLEAR;
                        Clr          <= 1'b1;
                        measure_mode <= ~measure_mode;
                        range_used   <= 1'b1;
                    end else begin
                        state <= ST_STORE;
                        Store <= 1'b1;
                        if (OF && measure_mode == MODE_COUNT) begin
                            over_range <= 1'b1;
                            over_hit   <= 1'b1;
                        end
                        if (OF && measure_mode == MODE_PERIOD) begin
                            under_range <= 1'b1;
                            under_hit   <= 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    // Flags from an earlier result stay visible through this Store, then drop.
                    over_range  <= over_hit;
                    under_range <= under_hit;
                    over_hit    <= 1'b0;
                    under_hit   <= 1'b0;
                    range_used  <= 1'b0;
                    cnt         <= '0;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        if (run) begin
                            state <= ST_CLEAR;
                            Clr   <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    Gate  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: directed range/flag scenarios plus randomized measurements,
// each checked against outcome and timing predictions made from the sequencer rules.
module tb_freq_meas_ctrl;
    import freq_meter_pkg::*;

    localparam int GATE_CYC    = 20;
    localparam int TIMEOUT_CYC = 60;
    localparam int SETTLE_CYC  = 2;
    localparam int HOLD_CYC    = 5;
    localparam int N_LOW       = 1000;

    localparam int OUT_OK    = 0;
    localparam int OUT_OVER  = 1;
    localparam int OUT_UNDER = 2;
    localparam int OUT_RANGE = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        run    = 1'b0;
    logic        sig_in = 1'b0;
    logic        of     = 1'b0;
    logic [3:0]  bcd3   = 4'd0;
    logic [3:0]  bcd2   = 4'd0;
    logic [15:0] n      = 16'd0;
    logic        clr, gate, store, mode, over, under, busy;

    int vectors     = 0;
    int miscompares = 0;
    int sig_period  = 0;

    logic       exp_mode  = MODE_COUNT;
    bit         chg_used  = 1'b0;
    logic       exp_over  = 1'b0;
    logic       exp_under = 1'b0;
    logic [1:0] exp_q[$];

    freq_meas_ctrl #(
        .GATE_CYC    (GATE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SETTLE_CYC  (SETTLE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .N_LOW       (N_LOW)
    ) dut (
        .CLK_50       (clk),
        .nRST         (rst_n),
        .run          (run),
        .sig_in       (sig_in),
        .OF           (of),
        .LatchBCD3    (bcd3),
        .LatchBCD2    (bcd2),
        .N            (n),
        .Clr          (clr),
        .Gate         (gate),
        .Store        (store),
        .measure_mode (mode),
        .over_range   (over),
        .under_range  (under),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Square wave whose period is picked up at each rising edge; 0 holds the line low.
    initial begin : sig_gen
        int phase;
        int cur;
        phase = 0;
        cur   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cur == 0) begin
                cur   = sig_period;
                phase = 0;
            end else begin
                phase++;
                if (phase >= cur) begin
                    phase = 0;
                    cur   = sig_period;
                end
            end
            sig_in = (cur != 0) && (phase < cur / 2);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int predict(input logic m, input logic m_of, input logic [3:0] d3,
                                   input logic [3:0] d2, input logic [15:0] nv,
                                   input bit no_signal, input bit used);
        if (m == MODE_PERIOD && no_signal) return OUT_UNDER;
        if (m_of) return (m == MODE_COUNT) ? OUT_OVER : OUT_UNDER;
        if (used) return OUT_OK;
        if (m == MODE_COUNT) return (d3 == 4'd0 && d2 == 4'd0) ? OUT_RANGE : OUT_OK;
        return (nv < 16'(N_LOW)) ? OUT_RANGE : OUT_OK;
    endfunction

    // Entered on the Clr cycle; leaves on the next Clr cycle (or in IDLE when last is set).
    task automatic measure(input logic m_of, input logic [3:0] d3, input logic [3:0] d2,
                           input logic [15:0] nv, input int per, input bit last);
        int  ghigh;
        int  gstart;
        int  first_low;
        int  outcome;
        bit  seen;
        bit  tmo;
        logic set_over;
        logic set_under;
        of = m_of;
        bcd3 = d3;
        bcd2 = d2;
        n = nv;
        sig_period = per;
        if (last) run = 1'b0;
        tmo = (exp_mode == MODE_PERIOD) && (per == 0);
        outcome = predict(exp_mode, m_of, d3, d2, nv, tmo, chg_used);
        set_over  = (outcome == OUT_OVER);
        set_under = (outcome == OUT_UNDER);
        if (outcome != OUT_RANGE) exp_q.push_back({exp_over | set_over, exp_under | set_under});
        check("mode_at_clr", mode, exp_mode);

        ghigh = 0;
        gstart = -1;
        first_low = -1;
        seen = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYC + 10; k++) begin
            @(negedge clk);
            if (k == 1) check("clr_width", clr, 1'b0);
            if (gate) begin
                ghigh++;
                if (!seen) gstart = k;
                seen = 1'b1;
            end else if (seen || store) begin
                first_low = k;
                break;
            end
        end
        if (first_low < 0) begin
            check("window_end_seen", 0, 1);
            return;
        end

        if (tmo) begin
            check("tmo_gate_never_high", ghigh, 0);
            check("tmo_store_after_arm", first_low - 1, TIMEOUT_CYC);
        end else begin
            if (exp_mode == MODE_COUNT) begin
                check("gate_open_after_clr", gstart, 1);
                check("gate_len_count", ghigh, GATE_CYC);
            end else begin
                check("gate_len_period", ghigh, per - 1);
            end
            check("settle_quiet", {store, clr}, 2'b00);
            for (int d = 1; d <= SETTLE_CYC; d++) begin
                @(negedge clk);
                check("settle_quiet", {store, clr}, 2'b00);
            end
            @(negedge clk);
        end

        if (outcome == OUT_RANGE) begin
            check("range_clr", clr, 1'b1);
            check("range_no_store", store, 1'b0);
            check("range_flags_kept", {over, under}, {exp_over, exp_under});
            exp_mode = ~exp_mode;
            chg_used = 1'b1;
            return;
        end

        check("store_strobe", store, 1'b1);
        check("store_no_clr", clr, 1'b0);
        if (exp_q.size() == 0) check("scoreboard_entry", 0, 1);
        else check("flags_at_store", {over, under}, exp_q.pop_front());
        @(negedge clk);
        check("store_width", store, 1'b0);
        check("flags_after_store", {over, under}, {set_over, set_under});
        check("mode_stable", mode, exp_mode);
        exp_over  = set_over;
        exp_under = set_under;
        chg_used  = 1'b0;
        for (int h = 2; h <= HOLD_CYC; h++) begin
            @(negedge clk);
            check("hold_quiet", clr, 1'b0);
        end
        @(negedge clk);
        if (last) check("idle_after_hold", {busy, clr}, 2'b00);
        else check("clr_after_hold", clr, 1'b1);
    endtask

    task automatic reset_mid_window();
        bit opened;
        opened = 1'b0;
        if (exp_mode == MODE_PERIOD && sig_period == 0) sig_period = 10;
        for (int k = 0; k < TIMEOUT_CYC + 10 && !opened; k++) begin
            @(negedge clk);
            opened = gate;
        end
        check("reset_window_open", opened, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {clr, gate, store, mode, over, under, busy}, 7'd0);
        @(negedge clk);
        check("reset_held_outputs", {clr, gate, store, mode, over, under, busy}, 7'd0);
        run   = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("clr_after_reset", clr, 1'b1);
        exp_mode  = MODE_COUNT;
        chg_used  = 1'b0;
        exp_over  = 1'b0;
        exp_under = 1'b0;
        exp_q.delete();
    endtask

    initial begin : main
        repeat (3) @(negedge clk);
        check("reset_outputs", {clr, gate, store, mode, over, under, busy}, 7'd0);
        run   = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("clr_after_release", clr, 1'b1);
        check("busy_after_release", busy, 1'b1);

        measure(1'b0, 4'd3, 4'd5, 16'd1234, 12, 1'b0);
        measure(1'b1, 4'd4, 4'd2, 16'd1234, 12, 1'b0);
        measure(1'b0, 4'd7, 4'd1, 16'd1234, 12, 1'b0);
        measure(1'b0, 4'd0, 4'd0, 16'd1234, 12, 1'b0);
        measure(1'b0, 4'd0, 4'd0, 16'd500, 12, 1'b0);
        measure(1'b0, 4'd0, 4'd0, 16'd500, 12, 1'b0);
        measure(1'b0, 4'd0, 4'd0, 16'd500, 0, 1'b0);
        measure(1'b0, 4'd6, 4'd6, 16'd3000, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic        r_of;
            logic [3:0]  r_d3;
            logic [3:0]  r_d2;
            logic [15:0] r_n;
            int          r_per;
            r_of = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                r_d3 = 4'd0;
                r_d2 = 4'd0;
            end else begin
                r_d3 = 4'($urandom_range(0, 9));
                r_d2 = 4'($urandom_range(1, 9));
            end
            r_n   = 16'($urandom_range(0, 2000));
            r_per = sig_period;
            if (exp_mode == MODE_COUNT)
                r_per = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(6, 20));
            else if (sig_period == 0 && $urandom_range(0, 1) == 1)
                r_per = int'($urandom_range(6, 20));
            measure(r_of, r_d3, r_d2, r_n, r_per, 1'b0);
        end

        reset_mid_window();
        measure(1'b0, 4'd3, 4'd5, 16'd1234, 8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
